operand_bus_arbiter: RTL and testbench
======================================

// Module: operand_bus_arbiter
// PURPOSE
//  Shares the registered 16-bit operand mux path between NREQ requesters (reg-file read, immediate unit,
//  ALU forward, load return). Round-robin arbitration with bounded bursts drives one registered
//  output slot with a valid/ready handshake toward the ALU operand input.
//  Sequences all operand-select decisions in the datapath; requesters never drive the mux directly.
// PARAMETERS
//  DATA_W    16  operand width
//  NREQ      4   number of requesters (>=2)
//  MAX_HOLD  4   max beats accepted per grant before forced release (>=1)
// PORTS
//  clk        in   1            rising-edge clock
//  rst_n      in   1            asynchronous reset, active-low
//  req        in   NREQ         per-requester beat pending
//  req_data   in   NREQ*DATA_W  requester i data at [i*DATA_W +: DATA_W]
//  req_last   in   NREQ         current beat is final of burst
//  gnt        out  NREQ         registered one-hot ownership (all-zero when idle)
//  req_ack    out  NREQ         comb: beat of requester i consumed this edge
//  out_data   out  DATA_W       registered operand to ALU
//  out_valid  out  1            out_data valid
//  out_ready  in   1            consumer accepts out_data this edge
//  busy       out  1            state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, ptr=0, owner=0, cnt=0, gnt=0, out_valid=0, out_data=0, busy=0;
//   in-flight beat discarded; outputs forced immediately, not at next edge.
//  out_free = !out_valid | out_ready.  accept = gnt[owner] & req[owner] & out_free.
//  req_ack[i] = accept & (i==owner); consumed beat must be replaced by requester on that edge.
//  IDLE: gnt=0. If |req: owner<=first set req scanning ptr, ptr+1, .. (mod NREQ); gnt<=onehot(owner);
//   cnt<=0; -> OWN. Else stay.
//  OWN: on accept: out_data<=req_data[owner], out_valid<=1, cnt<=cnt+1.
//   Release (-> IDLE, gnt<=0, ptr<=(owner+1) mod NREQ) at end of cycle when any of:
//   accept & req_last[owner]; accept & cnt==MAX_HOLD-1; !req[owner] (requester withdrew).
//  Output slot: if out_valid & out_ready & !accept -> out_valid<=0. Accept with out_ready=1 both
//   drains and refills same edge (full throughput). out_data stable while out_valid & !out_ready.
//  Latency: req rises cycle 0 (IDLE) -> gnt cycle 1 -> out_valid/out_data cycle 2. One IDLE cycle
//   always separates consecutive grants (including re-grant of same requester).
//  Boundaries: cnt never exceeds MAX_HOLD-1, no wrap; backpressure does not advance cnt; req of
//   non-owners ignored during OWN; ptr wraps NREQ-1 -> 0; req_data of non-granted sources ignored;
//   NREQ not power of 2 handled by explicit modulo compare.
// STRUCTURE
//  Package cpu_bus_pkg: DATA_W/NREQ defaults, arb_state_t enum {IDLE, OWN}, clog2-based IDX_W.
//  Sub-module rr_pick (combinational): inputs req[NREQ], ptr[IDX_W]; outputs idx[IDX_W], any.
//  Top: FSM, ptr/owner/cnt regs, output slot register, req_ack decode.
// TESTING
//  1 Reset mid-burst: rst_n=0 while out_valid=1, gnt=0010 -> gnt=0, out_valid=0, out_data=0 before next edge.
//  2 req0 only, data 0x1111 then 0x2222 (last), out_ready=1: gnt=0001 cyc1; out_data 0x1111 cyc2,
//    0x2222 cyc3; gnt=0 cyc3; ptr=1.
//  3 All req=1, never last, out_ready=1: grants 0,1,2,3,0 in order, 4 beats each, 1 idle cycle between.
//  4 Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data stable, req_ack=0, cnt frozen;
//    resumes on out_ready=1.
//  5 Owner 2 drops req after 2 beats -> gnt=0 next cycle, ptr=3; pending req1 granted after idle cycle.
//  6 ptr=2, req=1010 -> requester 3 granted first, then 1.

Source files
------------

// File: rtl/operand_bus_arbiter_pkg.sv
// Shared types and default sizing for the operand bus arbiter.
package operand_bus_arbiter_pkg;

    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_NREQ     = 4;
    localparam int unsigned DEF_MAX_HOLD = 4;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    // Index width for n entries; never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/operand_bus_arbiter_if.sv
// Requester-side and ALU-side handshake bundle of the operand bus arbiter.
interface operand_bus_arbiter_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREQ   = 4
);
    logic [NREQ-1:0]        req;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_last;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        req_ack;
    logic [DATA_W-1:0]      out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;

    modport master (
        output req, req_data, req_last, out_ready,
        input  gnt, req_ack, out_data, out_valid, busy
    );

    modport slave (
        input  req, req_data, req_last, out_ready,
        output gnt, req_ack, out_data, out_valid, busy
    );
endinterface

// File: rtl/operand_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at NREQ.
module operand_bus_arbiter_rr_pick #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int unsigned j;

    // Explicit modulo compare keeps non-power-of-two NREQ correct.
    always_comb begin
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = 32'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!any && req[IDX_W'(j)]) begin
                any = 1'b1;
                idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/operand_bus_arbiter.sv
// Round-robin, burst-bounded arbiter feeding one registered operand slot toward the ALU.
module operand_bus_arbiter
    import operand_bus_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned NREQ     = DEF_NREQ,
    parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
    input logic                 clk,
    input logic                 rst_n,
    operand_bus_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = idx_w(NREQ);
    localparam int unsigned CNT_W = idx_w(MAX_HOLD);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              busy_q, busy_d;

    logic              out_free;
    logic              accept;
    logic              release_c;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic [IDX_W-1:0]  owner_next;

    operand_bus_arbiter_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign out_free   = !out_valid_q || bus.out_ready;
    assign accept     = gnt_q[owner_q] && bus.req[owner_q] && out_free;
    assign owner_next = (owner_q == IDX_W'(NREQ - 1)) ? '0 : owner_q + IDX_W'(1);

    // Next-state, grant and output-slot update.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        release_c   = 1'b0;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.req_data[32'(owner_q) * DATA_W +: DATA_W];
            cnt_d       = cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_any) begin
                    owner_d = pick_idx;
                    gnt_d   = NREQ'(1) << pick_idx;
                    cnt_d   = '0;
                    state_d = OWN;
                end
            end
            OWN: begin
                release_c = (accept && (bus.req_last[owner_q] || cnt_q == CNT_W'(MAX_HOLD - 1)))
                            || !bus.req[owner_q];
                if (release_c) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = owner_next;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        busy_d = (state_d == OWN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.req_ack   = accept ? (NREQ'(1) << owner_q) : '0;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_operand_bus_arbiter.sv
// Scoreboard bench for operand_bus_arbiter: requester beat queues, expected operand and grant streams.
`timescale 1ns/1ps
module tb_operand_bus_arbiter;

    localparam int unsigned DW = 16;
    localparam int unsigned NR = 4;
    localparam int unsigned MH = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    operand_bus_arbiter_if #(.DATA_W(DW), .NREQ(NR)) bus();

    operand_bus_arbiter #(
        .DATA_W   (DW),
        .NREQ     (NR),
        .MAX_HOLD (MH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    beat_t         bq [NR][$];
    logic [DW-1:0] exp_q [$];
    int            exp_gnt [$];
    logic [NR-1:0] ack_pend = '0;
    logic [NR-1:0] prev_gnt = '0;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] bd(input int r, input int b);
        return DW'((r << 12) | (b & 32'hfff));
    endfunction

    function automatic bit queues_empty();
        for (int i = 0; i < NR; i++) begin
            if (bq[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic load_burst(input int r, input int b0, input int n, input bit last_end);
        beat_t bt;
        for (int k = 0; k < n; k++) begin
            bt.data = bd(r, b0 + k);
            bt.last = last_end && (k == n - 1);
            bq[r].push_back(bt);
        end
    endtask

    task automatic expect_burst(input int r, input int b0, input int n);
        exp_gnt.push_back(r);
        for (int k = 0; k < n; k++) exp_q.push_back(bd(r, b0 + k));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (n < 300 && !(queues_empty() && !bus.busy && !bus.out_valid && bus.gnt == '0));
        check_eq({tag, "_drain_timeout"}, 32'(n >= 300), 32'd0);
        check_eq({tag, "_sb_leftover"}, 32'(exp_q.size() + exp_gnt.size()), 32'd0);
    endtask

    // Requester model: retire acknowledged beats, then present the next one.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NR; i++) begin
            if (ack_pend[i] && bq[i].size() > 0) void'(bq[i].pop_front());
        end
        for (int i = 0; i < NR; i++) begin
            if (bq[i].size() > 0) begin
                bus.req[i]                = 1'b1;
                bus.req_data[i*DW +: DW]  = bq[i][0].data;
                bus.req_last[i]           = bq[i][0].last;
            end else begin
                bus.req[i]                = 1'b0;
                bus.req_data[i*DW +: DW]  = '0;
                bus.req_last[i]           = 1'b0;
            end
        end
    end

    // Monitor: operand handshakes and grant starts against the expected streams.
    always @(negedge clk) begin
        ack_pend = bus.req_ack;
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check_eq("sb_extra_beat", 32'(exp_q.size()), 32'd1);
                else check_eq("sb_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
            end
            if (bus.gnt != '0 && bus.gnt != prev_gnt) begin
                check_eq("gnt_idle_gap", 32'(prev_gnt), 32'd0);
                if (exp_gnt.size() == 0) check_eq("gnt_extra", 32'(bus.gnt), 32'd0);
                else check_eq("gnt_order", 32'(bus.gnt), 32'd1 << exp_gnt.pop_front());
            end
        end
        prev_gnt = rst_n ? bus.gnt : '0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_gnt",       32'(bus.gnt),       32'd0);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_out_data",  32'(bus.out_data),  32'd0);
        check_eq("rst_busy",      32'(bus.busy),      32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single requester, two-beat burst: latency and release on last.
        load_burst(0, 'h200, 2, 1'b1);
        exp_gnt.push_back(0);
        exp_q.push_back(16'h1111);
        exp_q.push_back(16'h2222);
        bq[0][0].data = 16'h1111;
        bq[0][1].data = 16'h2222;
        @(negedge clk);
        check_eq("t2_gnt_c0", 32'(bus.gnt), 32'd0);
        @(negedge clk);
        check_eq("t2_gnt_c1",   32'(bus.gnt),       32'b0001);
        check_eq("t2_valid_c1", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check_eq("t2_valid_c2", 32'(bus.out_valid), 32'd1);
        check_eq("t2_data_c2",  32'(bus.out_data),  32'h1111);
        @(negedge clk);
        check_eq("t2_data_c3",  32'(bus.out_data),  32'h2222);
        check_eq("t2_gnt_c3",   32'(bus.gnt),       32'd0);
        check_eq("t2_busy_c3",  32'(bus.busy),      32'd0);
        wait_idle("t2");

        // Asynchronous reset in the middle of a requester-1 burst.
        load_burst(1, 'h100, 6, 1'b0);
        expect_burst(1, 'h100, 4);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (n < 20 && !(bus.gnt == 4'b0010 && bus.out_valid));
        check_eq("t1_reach_burst", 32'(n >= 20), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t1_gnt",       32'(bus.gnt),       32'd0);
        check_eq("t1_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("t1_out_data",  32'(bus.out_data),  32'd0);
        check_eq("t1_busy",      32'(bus.busy),      32'd0);
        for (int i = 0; i < NR; i++) bq[i].delete();
        exp_q.delete();
        exp_gnt.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // All requesters, never last: 0,1,2,3,0 with MAX_HOLD beats each.
        load_burst(0, 'h300, 8, 1'b0);
        for (int r = 1; r < NR; r++) load_burst(r, 'h300, 4, 1'b0);
        for (int r = 0; r < NR; r++) expect_burst(r, 'h300, 4);
        expect_burst(0, 'h304, 4);
        wait_idle("t3");

        // Move ptr to 2 via a one-beat grant to requester 1, then req=1010.
        load_burst(1, 'h600, 1, 1'b1);
        expect_burst(1, 'h600, 1);
        wait_idle("t6a");
        load_burst(1, 'h610, 1, 1'b1);
        load_burst(3, 'h610, 1, 1'b1);
        expect_burst(3, 'h610, 1);
        expect_burst(1, 'h610, 1);
        wait_idle("t6");

        // Owner 2 withdraws after two beats; pending requester 1 follows.
        load_burst(2, 'h500, 2, 1'b0);
        load_burst(1, 'h500, 2, 1'b1);
        expect_burst(2, 'h500, 2);
        expect_burst(1, 'h500, 2);
        wait_idle("t5");

        // Backpressure for three edges in the middle of a requester-2 burst.
        load_burst(2, 'h400, 4, 1'b0);
        expect_burst(2, 'h400, 4);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (n < 20 && !bus.out_valid);
        check_eq("t4_reach_valid", 32'(n >= 20), 32'd0);
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("t4_hold_data",  32'(bus.out_data),  32'(bd(2, 'h401)));
            check_eq("t4_hold_valid", 32'(bus.out_valid), 32'd1);
            check_eq("t4_hold_ack",   32'(bus.req_ack),   32'd0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait_idle("t4");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
